vm_slot_arbiter: RTL and testbench
==================================

Name: vm_slot_arbiter

Overview:
- Owns the per-item inventory table (count and cost per slot) of the vm2002 vending machine.
- Arbitrates that table between two requesters: the supplier restock port and the customer vend controller.
- Serialises all read-modify-write accesses with a small FSM, so restock and vend can never corrupt the same slot.
- Returns a vend verdict, price and change to the vend controller, and a live sold-out vector for display/info logic.

Parameters:
NUM_ITEMS, 8, number of slots (1..8); item indices >= NUM_ITEMS are invalid
CNT_W, 4, count width per slot; saturates at 2**CNT_W-1 = 15
COST_W, 8, cost width per slot
BAL_W, 16, credit/change width

Ports:
clk  in  1  system clock, rising edge
hrst  in  1  hard reset, asynchronous, active-high; clears everything including the table
srst  in  1  soft reset, synchronous, active-high; aborts the transaction in flight, table retained
sup_valid  in  1  restock request; held until accepted
sup_item  in  3  slot to restock
sup_count  in  CNT_W  units to add
sup_cost  in  COST_W  new price; 0 = keep the current price
sup_ready  out  1  restock accepted this cycle (transfer = sup_valid & sup_ready)
sup_err  out  1  one-cycle pulse: accepted restock had an invalid item and was dropped
vend_req  in  1  vend request; level, held until vend_ack
vend_item  in  3  requested slot
vend_credit  in  BAL_W  customer balance
vend_ack  out  1  one-cycle registered pulse; result fields valid
vend_result  out  2  vend_status_t verdict
vend_cost  out  COST_W  price of the slot (0 if BAD_ITEM)
vend_change  out  BAL_W  credit-cost if VEND_OK, else 0
sold_out  out  NUM_ITEMS  bit i = 1 when count[i]==0, registered

Behaviour:
- hrst (async): state IDLE; all counts and costs 0; sold_out all 1s; sup_ready, sup_err, vend_ack 0; vend_result VEND_OK; vend_cost 0; vend_change 0; arbiter pointer set so the supplier wins the first tie.
- srst: takes priority over every other event. Forces IDLE; clears vend_ack and sup_err. A vend in CHK is dropped with no decrement and no ack. A restock captured but not yet committed is dropped. Table and arbiter pointer are unchanged.
- States: IDLE, SUP_WR, VEND_CHK, RESP.
- IDLE arbitration uses round-robin between sup_valid and vend_req; a single requester always wins. Only the winner sees the grant.
- sup_ready is combinational: (state==IDLE) & supplier granted. It is never high outside IDLE.
- Restock, edge N (transfer): capture item/count/cost, go to SUP_WR.
- Restock, edge N+1: commit count = min(count+sup_count, 15); cost overwritten if sup_cost!=0. Return to IDLE.
  - Invalid item: no table write; sup_err pulses in the cycle after N+1.
- Vend, edge N (IDLE, vend granted): capture item/credit, go to VEND_CHK.
- Vend, edge N+1: evaluate in priority order BAD_ITEM > SOLD_OUT (count==0) > LOW_CREDIT (credit<cost) > VEND_OK.
  - On VEND_OK, decrement count at this edge.
  - Register the results and go to RESP.
- Vend, cycle after N+1 (state RESP): vend_ack=1. Next edge returns to IDLE.
- Vend latency: ack 2 cycles after grant. Restock occupancy: 2 cycles.
- vend_req ack rule: the requester drops vend_req in the cycle vend_ack is high. vend_req seen in IDLE after RESP is a new request.
- Comparison credit<cost is done at BAL_W width with cost zero-extended.
- vend_change = credit-cost; it cannot underflow because it is only produced on OK.
- sold_out updates the cycle after any count change.
- Concurrent restock and vend to the same slot are serialised by the arbiter; the second sees the first's result.

Decomposition:
- vm2002_pkg holds:
  - vend_status_t: VEND_OK=0, SOLD_OUT=1, LOW_CREDIT=2, BAD_ITEM=3.
  - arb_state_t.
  - Constants MAX_ITEMS=8, CNT_W, COST_W, BAL_W.
- One sub-module: vm_rr_arb2 (2-requester round-robin; inputs req[1:0], advance; output gnt[1:0]; pointer flop on hrst).

Test Plan:
- hrst, then vend_req item 2, credit 50 -> ack at grant+2, vend_result=SOLD_OUT, vend_change=0, sold_out=8'hFF.
- Restock item 2, count 5, cost 30; then vend item 2, credit 50 -> VEND_OK, vend_cost=30, vend_change=20; next cycle count=4, sold_out[2]=0.
- Vend item 2, credit 20 -> LOW_CREDIT, count stays 4. Restock item 2, count 14, cost 0 -> count saturates at 15, cost stays 30.
- sup_valid and vend_req asserted together in IDLE twice in a row -> supplier granted first after reset, then vend, then supplier (alternation); each sup_ready pulse lasts one cycle.
- NUM_ITEMS=6: vend item 7 -> BAD_ITEM, vend_cost=0. Restock item 6 -> sup_err pulse, no table change.
- srst asserted in the VEND_CHK cycle of an OK vend -> no vend_ack, count unchanged, state IDLE. hrst mid-restock -> all counts 0, sold_out all 1s.

Source files
------------

// File: rtl/vm2002_pkg.sv
// vm2002 shared types and constants.
// Vend verdict and slot-arbiter state encodings, default widths.
package vm2002_pkg;

    localparam int MAX_ITEMS = 8;
    localparam int CNT_W     = 4;
    localparam int COST_W    = 8;
    localparam int BAL_W     = 16;

    typedef enum logic [1:0] {
        VEND_OK    = 2'd0,
        SOLD_OUT   = 2'd1,
        LOW_CREDIT = 2'd2,
        BAD_ITEM   = 2'd3
    } vend_status_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SUP_WR   = 2'd1,
        VEND_CHK = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/vm_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports: clk, hrst (async, active-high), req[1:0], advance -> gnt[1:0].
module vm_rr_arb2 (
    input  logic       clk,
    input  logic       hrst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // prio_q = 0 favours req[0] on a tie, 1 favours req[1]
    logic prio_q;

    assign gnt[0] = req[0] & (~req[1] | ~prio_q);
    assign gnt[1] = req[1] & (~req[0] |  prio_q);

    // After a grant, the other requester wins the next tie
    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            prio_q <= 1'b0;
        end else if (advance) begin
            prio_q <= gnt[0];
        end
    end

endmodule

// File: rtl/vm_slot_arbiter.sv
// vm2002 inventory table with restock/vend arbitration FSM.
// Ports: clk, hrst, srst; sup_* restock handshake; vend_* request/verdict; sold_out.
module vm_slot_arbiter #(
    parameter int NUM_ITEMS = 8,
    parameter int CNT_W     = 4,
    parameter int COST_W    = 8,
    parameter int BAL_W     = 16
) (
    input  logic                 clk,
    input  logic                 hrst,
    input  logic                 srst,
    input  logic                 sup_valid,
    input  logic [2:0]           sup_item,
    input  logic [CNT_W-1:0]     sup_count,
    input  logic [COST_W-1:0]    sup_cost,
    output logic                 sup_ready,
    output logic                 sup_err,
    input  logic                 vend_req,
    input  logic [2:0]           vend_item,
    input  logic [BAL_W-1:0]     vend_credit,
    output logic                 vend_ack,
    output logic [1:0]           vend_result,
    output logic [COST_W-1:0]    vend_cost,
    output logic [BAL_W-1:0]     vend_change,
    output logic [NUM_ITEMS-1:0] sold_out
);

    import vm2002_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       NI      = 4'(NUM_ITEMS);

    arb_state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q  [MAX_ITEMS];
    logic [COST_W-1:0] cost_q [MAX_ITEMS];

    logic [2:0]        item_q;
    logic [CNT_W-1:0]  add_q;
    logic [COST_W-1:0] newcost_q;
    logic [BAL_W-1:0]  credit_q;

    logic [1:0]        gnt;
    logic              idle;
    logic              sup_go;
    logic              vend_go;
    logic              advance;
    logic              item_ok;
    logic [CNT_W-1:0]  cnt_cur;
    logic [COST_W-1:0] cost_cur;
    logic [BAL_W-1:0]  cost_ext;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  sat;
    vend_status_t      verdict;

    vm_rr_arb2 u_arb (
        .clk     (clk),
        .hrst    (hrst),
        .req     ({vend_req, sup_valid}),
        .advance (advance),
        .gnt     (gnt)
    );

    // srst masks the grant so no handshake completes while aborting
    assign idle      = (state_q == IDLE);
    assign sup_go    = idle & gnt[0] & ~srst;
    assign vend_go   = idle & gnt[1] & ~srst;
    assign advance   = sup_go | vend_go;
    assign sup_ready = sup_go;

    assign item_ok  = ({1'b0, item_q} < NI);
    assign cnt_cur  = cnt_q[item_q];
    assign cost_cur = cost_q[item_q];
    assign cost_ext = BAL_W'(cost_cur);

    // Restock add saturates instead of wrapping
    assign sum = {1'b0, cnt_cur} + {1'b0, add_q};
    assign sat = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

    always_comb begin
        verdict = VEND_OK;
        if (!item_ok) begin
            verdict = BAD_ITEM;
        end else if (cnt_cur == '0) begin
            verdict = SOLD_OUT;
        end else if (credit_q < cost_ext) begin
            verdict = LOW_CREDIT;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sup_go) begin
                    state_d = SUP_WR;
                end else if (vend_go) begin
                    state_d = VEND_CHK;
                end
            end
            SUP_WR:   state_d = IDLE;
            VEND_CHK: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (srst) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            for (int i = 0; i < MAX_ITEMS; i++) begin
                cnt_q[i]  <= '0;
                cost_q[i] <= '0;
            end
            item_q      <= '0;
            add_q       <= '0;
            newcost_q   <= '0;
            credit_q    <= '0;
            sup_err     <= 1'b0;
            vend_ack    <= 1'b0;
            vend_result <= VEND_OK;
            vend_cost   <= '0;
            vend_change <= '0;
            sold_out    <= '1;
        end else begin
            sup_err  <= 1'b0;
            vend_ack <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                sold_out[i] <= (cnt_q[i] == '0);
            end
            if (!srst) begin
                if (sup_go) begin
                    item_q    <= sup_item;
                    add_q     <= sup_count;
                    newcost_q <= sup_cost;
                end
                if (vend_go) begin
                    item_q   <= vend_item;
                    credit_q <= vend_credit;
                end
                if (state_q == SUP_WR) begin
                    if (item_ok) begin
                        cnt_q[item_q] <= sat;
                        if (newcost_q != '0) begin
                            cost_q[item_q] <= newcost_q;
                        end
                    end else begin
                        sup_err <= 1'b1;
                    end
                end
                if (state_q == VEND_CHK) begin
                    vend_ack    <= 1'b1;
                    vend_result <= verdict;
                    vend_cost   <= item_ok ? cost_cur : '0;
                    vend_change <= (verdict == VEND_OK) ?
                                   credit_q - cost_ext : '0;
                    if (verdict == VEND_OK) begin
                        cnt_q[item_q] <= cnt_cur - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vm_slot_arbiter.sv
// Directed testbench for vm_slot_arbiter (NUM_ITEMS = 6).
// Drives restock/vend transactions and checks verdicts, handshakes, sold_out.
module tb_vm_slot_arbiter;

    localparam int NI = 6;

    logic          clk = 1'b0;
    logic          hrst, srst;
    logic          sup_valid;
    logic [2:0]    sup_item;
    logic [3:0]    sup_count;
    logic [7:0]    sup_cost;
    logic          sup_ready, sup_err;
    logic          vend_req;
    logic [2:0]    vend_item;
    logic [15:0]   vend_credit;
    logic          vend_ack;
    logic [1:0]    vend_result;
    logic [7:0]    vend_cost;
    logic [15:0]   vend_change;
    logic [NI-1:0] sold_out;

    always #5 clk = ~clk;

    vm_slot_arbiter #(.NUM_ITEMS(NI)) dut (
        .clk         (clk),
        .hrst        (hrst),
        .srst        (srst),
        .sup_valid   (sup_valid),
        .sup_item    (sup_item),
        .sup_count   (sup_count),
        .sup_cost    (sup_cost),
        .sup_ready   (sup_ready),
        .sup_err     (sup_err),
        .vend_req    (vend_req),
        .vend_item   (vend_item),
        .vend_credit (vend_credit),
        .vend_ack    (vend_ack),
        .vend_result (vend_result),
        .vend_cost   (vend_cost),
        .vend_change (vend_change),
        .sold_out    (sold_out)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_restock(input logic [2:0] it,
                              input logic [3:0] c,
                              input logic [7:0] p,
                              output logic err);
        int n;
        n = 0;
        @(negedge clk);
        sup_valid = 1'b1;
        sup_item  = it;
        sup_count = c;
        sup_cost  = p;
        #1;
        while (!sup_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!sup_ready) check("sup_ready timeout", sup_ready, 1);
        @(posedge clk);
        #1;
        sup_valid = 1'b0;
        @(posedge clk);
        #1;
        err = sup_err;
    endtask

    task automatic do_vend(input logic [2:0] it,
                           input logic [15:0] cr,
                           output logic [1:0] res,
                           output logic [7:0] cost,
                           output logic [15:0] chg,
                           output int lat);
        @(negedge clk);
        vend_req    = 1'b1;
        vend_item   = it;
        vend_credit = cr;
        @(posedge clk);
        #1;
        lat = 1;
        while (!vend_ack && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!vend_ack) check("vend_ack timeout", vend_ack, 1);
        vend_req = 1'b0;
        res  = vend_result;
        cost = vend_cost;
        chg  = vend_change;
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  r;
    logic [7:0]  cst;
    logic [15:0] chg;
    int          lat;
    logic        err;
    int          nok;
    logic [5:0]  pat;
    int          ackc;
    logic [1:0]  vres;
    logic [15:0] vchg;
    logic        acks;

    initial begin
        hrst = 1'b1; srst = 1'b0;
        sup_valid = 1'b0; sup_item = '0; sup_count = '0; sup_cost = '0;
        vend_req = 1'b0; vend_item = '0; vend_credit = '0;
        repeat (2) @(posedge clk);
        #1 hrst = 1'b0;

        check("rst sup_ready", sup_ready, 0);
        check("rst sup_err", sup_err, 0);
        check("rst vend_ack", vend_ack, 0);
        check("rst vend_result", vend_result, 0);
        check("rst vend_cost", vend_cost, 0);
        check("rst vend_change", vend_change, 0);
        check("rst sold_out", sold_out, 6'h3F);

        do_vend(3'd2, 16'd50, r, cst, chg, lat);
        check("empty latency", lat, 2);
        check("empty result", r, 1);
        check("empty change", chg, 0);
        check("empty cost", cst, 0);
        check("empty sold_out", sold_out, 6'h3F);

        do_restock(3'd2, 4'd5, 8'd30, err);
        check("rs1 err", err, 0);
        settle();
        check("rs1 sold_out", sold_out, 6'h3B);

        do_vend(3'd2, 16'd50, r, cst, chg, lat);
        check("ok result", r, 0);
        check("ok cost", cst, 30);
        check("ok change", chg, 20);
        settle();
        check("ok sold_out", sold_out, 6'h3B);

        do_vend(3'd2, 16'd20, r, cst, chg, lat);
        check("low result", r, 2);
        check("low cost", cst, 30);
        check("low change", chg, 0);

        do_restock(3'd2, 4'd14, 8'd0, err);
        check("sat err", err, 0);
        nok = 0;
        for (int k = 0; k < 16; k++) begin
            do_vend(3'd2, 16'd100, r, cst, chg, lat);
            if (k == 0) begin
                check("sat cost kept", cst, 30);
                check("sat change", chg, 70);
            end
            if (r == 2'd0) nok++;
        end
        check("sat vend count", nok, 15);
        check("sat last result", r, 1);
        settle();
        check("drained sold_out", sold_out, 6'h3F);

        do_vend(3'd7, 16'd50, r, cst, chg, lat);
        check("bad7 result", r, 3);
        check("bad7 cost", cst, 0);
        check("bad7 change", chg, 0);
        do_restock(3'd6, 4'd3, 8'd9, err);
        check("bad6 sup_err", err, 1);
        @(posedge clk);
        #1;
        check("sup_err pulse", sup_err, 0);
        do_vend(3'd6, 16'd50, r, cst, chg, lat);
        check("bad6 result", r, 3);
        do_vend(3'd5, 16'd50, r, cst, chg, lat);
        check("last slot result", r, 1);
        settle();
        check("bad6 sold_out", sold_out, 6'h3F);

        @(negedge clk);
        hrst = 1'b1;
        #2 hrst = 1'b0;
        @(negedge clk);
        sup_valid = 1'b1; sup_item = 3'd1; sup_count = 4'd1; sup_cost = 8'd5;
        vend_req = 1'b1; vend_item = 3'd1; vend_credit = 16'd100;
        ackc = -1; vres = '1; vchg = '1;
        for (int c = 0; c < 6; c++) begin
            #1;
            pat[c] = sup_ready;
            if (vend_ack) begin
                ackc = c;
                vres = vend_result;
                vchg = vend_change;
                vend_req = 1'b0;
            end
            @(negedge clk);
        end
        sup_valid = 1'b0;
        check("rr pattern", pat, 6'b100001);
        check("rr ack cycle", ackc, 4);
        check("rr vend result", vres, 0);
        check("rr vend change", vchg, 95);
        settle();
        check("rr sold_out", sold_out, 6'h3D);

        do_restock(3'd3, 4'd1, 8'd10, err);
        settle();
        check("srst pre sold_out", sold_out, 6'h35);
        @(negedge clk);
        vend_req = 1'b1; vend_item = 3'd3; vend_credit = 16'd10;
        @(posedge clk);
        #1;
        srst = 1'b1;
        vend_req = 1'b0;
        @(posedge clk);
        #1;
        srst = 1'b0;
        acks = 1'b0;
        for (int c = 0; c < 4; c++) begin
            acks = acks | vend_ack;
            @(posedge clk);
            #1;
        end
        check("srst no ack", acks, 0);
        do_vend(3'd3, 16'd10, r, cst, chg, lat);
        check("srst kept result", r, 0);
        check("srst kept cost", cst, 10);
        check("srst kept change", chg, 0);
        settle();
        check("srst post sold_out", sold_out, 6'h3D);

        @(negedge clk);
        sup_valid = 1'b1; sup_item = 3'd4; sup_count = 4'd3; sup_cost = 8'd7;
        #1;
        check("mid sup_ready", sup_ready, 1);
        @(posedge clk);
        #1;
        sup_valid = 1'b0;
        hrst = 1'b1;
        #1;
        check("hrst sold_out", sold_out, 6'h3F);
        check("hrst sup_ready", sup_ready, 0);
        #2 hrst = 1'b0;
        do_vend(3'd1, 16'd100, r, cst, chg, lat);
        check("hrst item1 result", r, 1);
        check("hrst item1 cost", cst, 0);
        do_vend(3'd4, 16'd100, r, cst, chg, lat);
        check("hrst item4 result", r, 1);
        settle();
        check("hrst final sold_out", sold_out, 6'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
